ram_port_access_ctrl: RTL and testbench
=======================================

Name: ram_port_access_ctrl

Overview:
Upstream request controller for one port of dual_port_ram_with_latencies. It converts a valid/ready request stream into single-cycle RAM port strobes (en/we/addr/din) and tracks the port's fixed read latency. Returned read data is buffered in order in a response FIFO with backpressure. Reads to an address that still has a write in flight inside the RAM write pipeline are stalled. One instance is placed per RAM port, in that port's clock domain.

Parameters:
DATA_WIDTH, 8, data bus width; must match the RAM.
ADDR_WIDTH, 3, address width; must match the RAM.
WRITE_LATENCY, 5, cycles from a write strobe until the array is updated; must match the RAM port.
READ_LATENCY, 4, cycles from a read strobe until i_dout is valid; must match the RAM port; ≥1.
MAX_OUTSTANDING, 4, response FIFO depth and cap on reads in flight plus buffered; ≥1.

Ports:
i_clk  in  1  port clock (same clock as the attached RAM port).
i_rst_n  in  1  asynchronous active-low reset.
i_req_valid  in  1  request valid.
o_req_ready  out  1  request accepted when valid&ready at posedge.
i_req_we  in  1  1 = write, 0 = read.
i_req_addr  in  ADDR_WIDTH  request address.
i_req_wdata  in  DATA_WIDTH  write data.
o_rsp_valid  out  1  read response valid (FIFO non-empty).
i_rsp_ready  in  1  response consumer ready.
o_rsp_data  out  DATA_WIDTH  read data, FIFO head.
o_en  out  1  RAM port enable.
o_we  out  1  RAM port write enable.
o_addr  out  ADDR_WIDTH  RAM port address.
o_din  out  DATA_WIDTH  RAM port write data.
i_dout  in  DATA_WIDTH  RAM port read data.

Behaviour:
- Reset (async assert, sync release): o_en=0, o_we=0, o_addr=0, o_din=0, o_rsp_valid=0, o_rsp_data=0, o_req_ready=0. All pipelines, the FIFO and the credit counter are cleared.
- Reset mid-operation: in-flight reads are dropped, the FIFO is emptied, write tracking is cleared, and no response is ever emitted for pre-reset reads.
- Accept at posedge k: o_en=1 and o_we=i_req_we during cycle k+1 only, with o_addr/o_din registered from the request. With no accept, o_en=0 and o_we=0, and o_addr/o_din hold their values.
- Throughput: one request per cycle maximum.
- Read latency: for a read strobe in cycle k+1, i_dout is sampled at the end of cycle k+1+READ_LATENCY. A READ_LATENCY-deep valid shift register is used, with no data tags. Sampled data is pushed into the FIFO. Responses are strictly in order.
- Credits: outstanding = reads in the shift register + FIFO occupancy.
  - A read is not accepted when outstanding == MAX_OUTSTANDING.
  - A response pop in the same cycle does not free the credit until the next cycle; a registered count is used.
  - Writes never consume credits.
- Write hazard: a WRITE_LATENCY-deep shift register holds {valid, addr} of issued writes.
  - A read whose i_req_addr matches any valid entry, or matches the write currently being strobed, is not accepted.
  - Writes are never hazard-stalled; write-after-write completes in order.
- o_req_ready = !reset & !(read & (credit_full | addr_hazard)). It may combinationally depend on i_req_we and i_req_addr. It does not depend on i_req_valid.
- FIFO: o_rsp_valid = !empty, and o_rsp_data = head. Pop on o_rsp_valid & i_rsp_ready. Push and pop in the same cycle are legal, including when full or empty. Overflow cannot occur by construction; a bench assertion checks it.
- Wrap-around: FIFO pointers are modulo MAX_OUTSTANDING and need not be a power of two. The address is used as-is, with no increment logic.

Test Plan:
1. Reset, then write 0xA0/0xA1/0xA2 to addr 0/1/2 back-to-back -> o_en=o_we=1 for 3 consecutive cycles starting 1 cycle after the first accept, with o_addr 0,1,2 and o_din A0,A1,A2; o_req_ready stays 1 throughout.
2. After writes retire (WRITE_LATENCY+2 idle cycles), read 0,1,2 back-to-back with i_rsp_ready=1 -> o_rsp_valid is first asserted exactly 1+READ_LATENCY+1 cycles after the first accept, data A0,A1,A2 on consecutive cycles.
3. Write 0x55 to addr 3, then immediately request a read of addr 3 -> o_req_ready=0 for the read until the write leaves the WRITE_LATENCY tracker; the read then returns 0x55.
4. Hold i_rsp_ready=0 and issue 6 reads -> exactly MAX_OUTSTANDING=4 are accepted and o_req_ready stays 0. With a write pending, o_req_ready=1 and the write is accepted. Releasing i_rsp_ready drains 4 in-order responses, then the remaining 2 reads are accepted.
5. Full FIFO with simultaneous pop and final pipeline push -> no data lost or duplicated; the sequence matches the scoreboard.
6. Assert i_rst_n low with 2 reads in flight and 1 buffered -> all outputs reach reset values immediately; after release, no o_rsp_valid appears for 10 cycles and new requests behave as in scenario 1.

Source files
------------

// File: rtl/ram_port_access_ctrl_if.sv
// rtl/ram_port_access_ctrl_if.sv - request, response and RAM strobe bundle for one RAM port
interface ram_port_access_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_we;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic [DATA_WIDTH-1:0] i_req_wdata;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [DATA_WIDTH-1:0] o_rsp_data;
  logic                  o_en;
  logic                  o_we;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic [DATA_WIDTH-1:0] o_din;
  logic [DATA_WIDTH-1:0] i_dout;

  // Controller side
  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_rsp_ready, i_dout,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_en, o_we, o_addr, o_din
  );

  // Requester and RAM side
  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_rsp_ready, i_dout,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_en, o_we, o_addr, o_din
  );
endinterface

// File: rtl/ram_port_access_ctrl.sv
// rtl/ram_port_access_ctrl.sv - request controller with read latency tracking and response FIFO
module ram_port_access_ctrl #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 3,
  parameter int WRITE_LATENCY   = 5,
  parameter int READ_LATENCY    = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  ram_port_access_ctrl_if.slave bus
);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);

  logic                  active;
  logic [CNT_W-1:0]      credit_cnt;
  logic [READ_LATENCY-1:0]  rd_vld;
  logic [WRITE_LATENCY-1:0] wr_vld;
  logic [ADDR_WIDTH-1:0] wr_addr [WRITE_LATENCY];
  logic [DATA_WIDTH-1:0] fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;
  logic                  addr_hazard;
  logic                  credit_full;
  logic                  accept;
  logic                  rd_accept;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // A read must not overtake a write still travelling through the RAM write pipeline
  always_comb begin
    addr_hazard = bus.o_en && bus.o_we && (bus.o_addr == bus.i_req_addr);
    for (int i = 0; i < WRITE_LATENCY; i++) begin
      if (wr_vld[i] && (wr_addr[i] == bus.i_req_addr)) addr_hazard = 1'b1;
    end
  end

  assign credit_full     = (credit_cnt == MAX_CNT);
  assign bus.o_req_ready = active && !(!bus.i_req_we && (credit_full || addr_hazard));
  assign accept          = bus.i_req_valid && bus.o_req_ready;
  assign rd_accept       = accept && !bus.i_req_we;
  assign fifo_push       = rd_vld[READ_LATENCY-1];
  assign fifo_empty      = (fifo_cnt == '0);
  assign fifo_pop        = !fifo_empty && bus.i_rsp_ready;
  assign bus.o_rsp_valid = !fifo_empty;
  assign bus.o_rsp_data  = fifo_empty ? '0 : fifo_mem[rd_ptr];

  // Hold off acceptance until the first edge after reset release
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) active <= 1'b0;
    else          active <= 1'b1;
  end

  // One-cycle RAM strobe per accepted request; address and data hold when idle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_en   <= 1'b0;
      bus.o_we   <= 1'b0;
      bus.o_addr <= '0;
      bus.o_din  <= '0;
    end else begin
      bus.o_en <= accept;
      bus.o_we <= accept && bus.i_req_we;
      if (accept) begin
        bus.o_addr <= bus.i_req_addr;
        bus.o_din  <= bus.i_req_wdata;
      end
    end
  end

  // Read valid pipeline: the last stage marks the cycle i_dout carries read data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_vld <= '0;
    end else begin
      rd_vld[0] <= bus.o_en && !bus.o_we;
      for (int i = 1; i < READ_LATENCY; i++) rd_vld[i] <= rd_vld[i-1];
    end
  end

  // Write tracker: addresses of writes not yet committed to the array
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_vld <= '0;
      for (int i = 0; i < WRITE_LATENCY; i++) wr_addr[i] <= '0;
    end else begin
      wr_vld[0]  <= bus.o_en && bus.o_we;
      wr_addr[0] <= bus.o_addr;
      for (int i = 1; i < WRITE_LATENCY; i++) begin
        wr_vld[i]  <= wr_vld[i-1];
        wr_addr[i] <= wr_addr[i-1];
      end
    end
  end

  // Credits cover reads from acceptance until their response is popped
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      credit_cnt <= '0;
    end else if (rd_accept && !fifo_pop) begin
      credit_cnt <= credit_cnt + CNT_W'(1);
    end else if (!rd_accept && fifo_pop) begin
      credit_cnt <= credit_cnt - CNT_W'(1);
    end
  end

  // Response FIFO pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= ptr_inc(wr_ptr);
      if (fifo_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (fifo_push && !fifo_pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (!fifo_push && fifo_pop) fifo_cnt <= fifo_cnt - CNT_W'(1);
    end
  end

  // Response FIFO storage; contents are only visible while occupancy is non-zero
  always_ff @(posedge i_clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= bus.i_dout;
  end
endmodule

// File: tb/tb_ram_port_access_ctrl.sv
// tb/tb_ram_port_access_ctrl.sv - scoreboard bench for ram_port_access_ctrl
module tb_ram_port_access_ctrl;
  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int WL   = 5;
  localparam int RL   = 4;
  localparam int MAXO = 4;

  typedef struct {
    int            due;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } strobe_t;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ram_op_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   last_acc = 0;

  strobe_t       strb_q[$];
  logic [DW-1:0] rsp_q[$];
  logic [DW-1:0] shadow [8];
  logic [DW-1:0] ram [8] = '{default: '0};
  ram_op_t       ram_wq[$];
  ram_op_t       ram_rq[$];

  ram_port_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_port_access_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_LATENCY(WL),
    .READ_LATENCY(RL), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RAM port model: writes commit after WL cycles, read data presented RL cycles after the strobe
  always @(negedge clk) begin
    ram_op_t op;
    while (ram_wq.size() > 0 && ram_wq[0].due <= cyc) begin
      op = ram_wq.pop_front();
      ram[op.addr] = op.data;
    end
    if (bus.o_en && bus.o_we) begin
      op.due = cyc + WL; op.addr = bus.o_addr; op.data = bus.o_din;
      ram_wq.push_back(op);
    end else if (bus.o_en) begin
      op.due = cyc + RL; op.addr = bus.o_addr; op.data = ram[bus.o_addr];
      ram_rq.push_back(op);
    end
    if (ram_rq.size() > 0 && ram_rq[0].due == cyc) begin
      op = ram_rq.pop_front();
      bus.i_dout = op.data;
    end else begin
      bus.i_dout = 8'hEE;
    end
  end

  // Monitor: strobes and responses against the scoreboard queues
  always @(negedge clk) begin
    strobe_t s;
    if (rst_n) begin
      if (strb_q.size() > 0 && strb_q[0].due == cyc) begin
        s = strb_q.pop_front();
        check("strobe_en", bus.o_en, 1);
        check("strobe_we", bus.o_we, s.we);
        check("strobe_addr", bus.o_addr, s.addr);
        check("strobe_din", bus.o_din, s.din);
      end else begin
        check("idle_en", bus.o_en, 0);
        check("idle_we", bus.o_we, 0);
      end
      if (bus.o_rsp_valid && bus.i_rsp_ready) begin
        if (rsp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_rsp: got %0h expected no response (cycle %0d)", bus.o_rsp_data, cyc);
        end else begin
          check("rsp_data", bus.o_rsp_data, rsp_q.pop_front());
        end
      end
      check("no_overflow", rsp_q.size() <= MAXO, 1);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one request; returns the number of cycles it waited for ready
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input int max_wait, output int waited);
    strobe_t s;
    bus.i_req_valid = 1'b1;
    bus.i_req_we    = we;
    bus.i_req_addr  = addr;
    bus.i_req_wdata = data;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.o_req_ready || waited >= max_wait) break;
      waited++;
      @(posedge clk); #1;
    end
    if (bus.o_req_ready) begin
      s.due = cyc + 1; s.we = we; s.addr = addr; s.din = data;
      strb_q.push_back(s);
      if (we) shadow[addr] = data;
      else    rsp_q.push_back(shadow[addr]);
      last_acc = cyc;
      @(posedge clk); #1;
    end else begin
      n_assert++;
      n_fail++;
      $display("FAIL req_timeout: got no accept after %0d cycles, expected accept (addr %0d)", waited, addr);
    end
    bus.i_req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (rsp_q.size() > 0 && n < 40) begin @(negedge clk); n++; end
    check(name, rsp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset(input string name);
    check({name, "_en"}, bus.o_en, 0);
    check({name, "_we"}, bus.o_we, 0);
    check({name, "_addr"}, bus.o_addr, 0);
    check({name, "_din"}, bus.o_din, 0);
    check({name, "_rsp_valid"}, bus.o_rsp_valid, 0);
    check({name, "_rsp_data"}, bus.o_rsp_data, 0);
    check({name, "_req_ready"}, bus.o_req_ready, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int c0;
    int n;
    bus.i_req_valid = 1'b0;
    bus.i_req_we    = 1'b0;
    bus.i_req_addr  = '0;
    bus.i_req_wdata = '0;
    bus.i_rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) shadow[i] = '0;

    #2 check_reset("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // 1: back-to-back writes
    for (int i = 0; i < 3; i++) begin
      do_req(1'b1, AW'(i), DW'(8'hA0 + i), 4, w);
      check("t1_wait", w, 0);
    end
    idle(WL + 2);

    // 2: back-to-back reads, first response latency
    do_req(1'b0, 3'd0, 8'h00, 4, w);
    c0 = last_acc;
    check("t2_wait", w, 0);
    do_req(1'b0, 3'd1, 8'h00, 4, w);
    do_req(1'b0, 3'd2, 8'h00, 4, w);
    n = 0;
    @(negedge clk);
    while (!bus.o_rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("t2_first_rsp_cycle", cyc, c0 + RL + 2);
    wait_drain("t2_drain");

    // 3: read-after-write hazard
    do_req(1'b1, 3'd3, 8'h55, 4, w);
    do_req(1'b0, 3'd3, 8'h00, 30, w);
    check("t3_stall_cycles", w, WL + 1);
    wait_drain("t3_drain");

    // 4: credit limit with responses held off
    bus.i_rsp_ready = 1'b0;
    for (int i = 0; i < MAXO; i++) begin
      do_req(1'b0, AW'(i), 8'h00, 4, w);
      check("t4_fill_wait", w, 0);
    end
    bus.i_req_valid = 1'b1;
    bus.i_req_we    = 1'b0;
    bus.i_req_addr  = 3'd0;
    bus.i_req_wdata = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t4_ready_low", bus.o_req_ready, 0);
      @(posedge clk); #1;
    end
    do_req(1'b1, 3'd6, 8'h66, 4, w);
    check("t4_write_wait", w, 0);
    bus.i_rsp_ready = 1'b1;
    do_req(1'b0, 3'd0, 8'h00, 10, w);
    check("t4_credit_lag", w, 1);
    do_req(1'b0, 3'd1, 8'h00, 10, w);
    check("t4_sixth_wait", w, 0);
    wait_drain("t4_drain");

    // 5: pop coincides with the final pipeline push into a nearly full FIFO
    bus.i_rsp_ready = 1'b0;
    do_req(1'b0, 3'd2, 8'h00, 4, w);
    c0 = last_acc;
    do_req(1'b0, 3'd1, 8'h00, 4, w);
    do_req(1'b0, 3'd0, 8'h00, 4, w);
    do_req(1'b0, 3'd3, 8'h00, 4, w);
    while (cyc < c0 + RL + 4) begin @(posedge clk); #1; end
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    check("t5_rsp_valid", bus.o_rsp_valid, 1);
    wait_drain("t5_drain");

    // 6: reset with two reads in flight and one buffered
    bus.i_rsp_ready = 1'b0;
    do_req(1'b0, 3'd0, 8'h00, 4, w);
    c0 = last_acc;
    do_req(1'b0, 3'd1, 8'h00, 4, w);
    do_req(1'b0, 3'd2, 8'h00, 4, w);
    n = 0;
    @(negedge clk);
    while (!bus.o_rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("t6_buffered_cycle", cyc, c0 + RL + 2);
    #1 rst_n = 1'b0;
    #1 check_reset("t6_reset");
    rsp_q.delete();
    strb_q.delete();
    bus.i_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_no_rsp", bus.o_rsp_valid, 0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      do_req(1'b1, AW'(4 + i), DW'(8'hB0 + i), 4, w);
      check("t6_write_wait", w, 0);
    end
    idle(WL + 2);
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, AW'(4 + i), 8'h00, 4, w);
      check("t6_read_wait", w, 0);
    end
    wait_drain("t6_drain");

    idle(2);
    check("end_strobes_pending", strb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
